// File: rtl/aer_rx_decoder.sv
// AER receiver: synchronises the 2-bit four-phase handshake link, reassembles
// ADDR_W/2 symbols (MSB pair first) into an event address, presents it on valid/ready.
module aer_rx_decoder #(
  parameter int ADDR_W  = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aer_req,
  input  logic              aer_bit0,
  input  logic              aer_bit1,
  output logic              aer_ack,
  output logic [ADDR_W-1:0] ev_addr,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              frame_err
);

  localparam int NSYM  = ADDR_W / 2;
  localparam int SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SH_W  = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NSYM - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_ACK
  } state_t;

  logic [1:0]        r_req_sy;
  logic [1:0]        r_b0_sy;
  logic [1:0]        r_b1_sy;
  logic              w_req_s;
  logic              w_b0_s;
  logic              w_b1_s;

  state_t            r_state;
  logic [SET_W-1:0]  r_settle;
  logic [SYM_W-1:0]  r_sym;
  logic [SH_W-1:0]   r_shift;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_ack;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic              r_ferr;

  state_t            w_state_nxt;
  logic [SET_W-1:0]  w_settle_nxt;
  logic [SYM_W-1:0]  w_sym_nxt;
  logic [SH_W-1:0]   w_shift_nxt;
  logic [TMO_W-1:0]  w_tmo_nxt;
  logic              w_ack_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_valid_nxt;
  logic              w_ferr_nxt;
  logic              w_take;
  logic              w_last;
  logic              w_stall;
  logic [ADDR_W-1:0] w_cat;

  // Two-flop synchronisers; nothing else looks at the raw link inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_sy <= '0;
      r_b0_sy  <= '0;
      r_b1_sy  <= '0;
    end else begin
      r_req_sy <= {r_req_sy[0], aer_req};
      r_b0_sy  <= {r_b0_sy[0], aer_bit0};
      r_b1_sy  <= {r_b1_sy[0], aer_bit1};
    end
  end

  assign w_req_s = r_req_sy[1];
  assign w_b0_s  = r_b0_sy[1];
  assign w_b1_s  = r_b1_sy[1];

  // Register holds only the earlier symbols of the frame; w_cat is the frame so far
  if (ADDR_W > 2) begin : g_wide
    assign w_cat = {r_shift, w_b1_s, w_b0_s};
  end else begin : g_narrow
    assign w_cat = {w_b1_s, w_b0_s};
  end

  assign w_last  = (r_sym == SYM_LAST);
  assign w_stall = w_last && r_valid && !ev_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_sym    <= '0;
      r_shift  <= '0;
      r_tmo    <= '0;
      r_ack    <= 1'b0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_sym    <= w_sym_nxt;
      r_shift  <= w_shift_nxt;
      r_tmo    <= w_tmo_nxt;
      r_ack    <= w_ack_nxt;
      r_addr   <= w_addr_nxt;
      r_valid  <= w_valid_nxt;
      r_ferr   <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_sym_nxt    = r_sym;
    w_shift_nxt  = r_shift;
    w_tmo_nxt    = '0;
    w_ack_nxt    = r_ack;
    w_addr_nxt   = r_addr;
    w_valid_nxt  = r_valid;
    w_ferr_nxt   = 1'b0;
    w_take       = 1'b0;

    if (r_valid && ev_ready) begin
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        w_ack_nxt = 1'b0;
        if (w_req_s) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = '0;
        end else if (r_sym != '0) begin
          // Partial frame is waiting for its next symbol
          if (r_tmo == TMO_LAST) begin
            w_sym_nxt   = '0;
            w_shift_nxt = '0;
            w_ferr_nxt  = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (!w_req_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_settle == SET_LAST) begin
          w_take = 1'b1;
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      S_SAMPLE: begin
        w_take = 1'b1;
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Sampling is folded into the final settle cycle so ack rises SETTLE+3 after req
    if (w_take) begin
      if (w_stall) begin
        w_state_nxt = S_SAMPLE;
      end else begin
        w_shift_nxt = w_cat[SH_W-1:0];
        w_ack_nxt   = 1'b1;
        w_state_nxt = S_ACK;
        if (w_last) begin
          w_addr_nxt  = w_cat;
          w_valid_nxt = 1'b1;
          w_sym_nxt   = '0;
        end else begin
          w_sym_nxt = r_sym + 1'b1;
        end
      end
    end
  end

  assign aer_ack   = r_ack;
  assign ev_addr   = r_addr;
  assign ev_valid  = r_valid;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_aer_rx_decoder.sv
// Bench for aer_rx_decoder: a sender model drives four-phase handshakes and queues
// expected addresses; a monitor pops and compares on every accepted event.
module tb_aer_rx_decoder;

  localparam int ADDR_W = 8;
  localparam int NSYM   = ADDR_W / 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              aer_req = 1'b0;
  logic              aer_bit0 = 1'b0;
  logic              aer_bit1 = 1'b0;
  logic              aer_ack;
  logic [ADDR_W-1:0] ev_addr;
  logic              ev_valid;
  logic              ev_ready = 1'b0;
  logic              frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int ferr_seen = 0;
  int rise_n, fall_n;
  logic [ADDR_W-1:0] exp_q[$];

  aer_rx_decoder #(.ADDR_W(ADDR_W), .SETTLE(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .aer_req(aer_req), .aer_bit0(aer_bit0),
    .aer_bit1(aer_bit1), .aer_ack(aer_ack), .ev_addr(ev_addr),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted event must match the oldest queued expectation
  initial begin
    logic [ADDR_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && frame_err) ferr_seen++;
      if (!reset && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          check("ev_unexpected", int'(ev_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check("ev_addr", int'(ev_addr), int'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_sym(input logic [1:0] s, output int rn, output int fn);
    int n;
    aer_bit1 = s[1];
    aer_bit0 = s[0];
    aer_req  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!aer_ack && n < 200);
    rn = n;
    if (!aer_ack) check("ack_rise_timeout", 0, 1);
    aer_req = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (aer_ack && n < 200);
    fn = n;
    if (aer_ack) check("ack_fall_timeout", 1, 0);
    aer_bit1 = 1'b0;
    aer_bit0 = 1'b0;
  endtask

  task automatic send_frame(input logic [ADDR_W-1:0] a);
    int rn, fn;
    exp_q.push_back(a);
    for (int i = NSYM - 1; i >= 0; i--) send_sym(a[2*i +: 2], rn, fn);
  endtask

  initial begin
    int n, got, acks;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_ack", int'(aer_ack), 0);
    check("rst_valid", int'(ev_valid), 0);
    check("rst_addr", int'(ev_addr), 0);
    check("rst_ferr", int'(frame_err), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Single frame 0x9C with latency checks on the first symbol
    ev_ready = 1'b1;
    exp_q.push_back(8'h9C);
    send_sym(2'b10, rise_n, fall_n);
    check("ack_rise_latency", rise_n, 5);
    check("ack_fall_latency", fall_n, 3);
    send_sym(2'b01, rise_n, fall_n);
    send_sym(2'b11, rise_n, fall_n);
    send_sym(2'b00, rise_n, fall_n);
    repeat (4) @(posedge clk); #1;
    check("single_valid_clear", int'(ev_valid), 0);

    // Back-pressure: 0xA5 held, 0x3C's last symbol stalls until ready
    ev_ready = 1'b0;
    send_frame(8'hA5);
    repeat (3) @(posedge clk); #1;
    check("bp_valid", int'(ev_valid), 1);
    check("bp_addr_a5", int'(ev_addr), 8'hA5);
    exp_q.push_back(8'h3C);
    send_sym(2'b00, rise_n, fall_n);
    send_sym(2'b11, rise_n, fall_n);
    send_sym(2'b11, rise_n, fall_n);
    check("bp_hold_addr", int'(ev_addr), 8'hA5);
    fork
      send_sym(2'b00, rise_n, fall_n);
      begin
        repeat (20) @(posedge clk);
        #2;
        check("bp_stall_ack", int'(aer_ack), 0);
        check("bp_stall_addr", int'(ev_addr), 8'hA5);
        check("bp_stall_valid", int'(ev_valid), 1);
        ev_ready = 1'b1;
        @(posedge clk); #1;
        check("simul_valid", int'(ev_valid), 1);
        check("simul_addr", int'(ev_addr), 8'h3C);
        check("simul_ack", int'(aer_ack), 1);
      end
    join
    repeat (3) @(posedge clk); #1;

    // Glitch: req high for only two cycles
    aer_bit1 = 1'b1;
    aer_bit0 = 1'b1;
    aer_req  = 1'b1;
    repeat (2) @(posedge clk); #1;
    aer_req  = 1'b0;
    aer_bit1 = 1'b0;
    aer_bit0 = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (aer_ack) acks++;
    end
    check("glitch_no_ack", acks, 0);
    check("glitch_valid", int'(ev_valid), 0);
    send_frame(8'h4B);

    // Timeout with a pending event that must survive
    ev_ready = 1'b0;
    send_frame(8'h66);
    send_sym(2'b11, rise_n, fall_n);
    send_sym(2'b11, rise_n, fall_n);
    n = 0;
    got = 0;
    while (n < 100 && got == 0) begin
      @(posedge clk); #1; n++;
      if (frame_err) got = n;
    end
    check("tmo_latency", got, 64);
    @(posedge clk); #1;
    check("tmo_pulse_width", int'(frame_err), 0);
    check("tmo_valid_kept", int'(ev_valid), 1);
    check("tmo_addr_kept", int'(ev_addr), 8'h66);
    ev_ready = 1'b1;
    send_frame(8'hFF);
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of symbol 3 with an event pending
    ev_ready = 1'b0;
    send_frame(8'h77);
    send_sym(2'b00, rise_n, fall_n);
    send_sym(2'b01, rise_n, fall_n);
    aer_bit1 = 1'b1;
    aer_bit0 = 1'b0;
    aer_req  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!aer_ack && n < 200);
    check("rst_mid_pre_ack", int'(aer_ack), 1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_ack", int'(aer_ack), 0);
    check("rst_mid_valid", int'(ev_valid), 0);
    exp_q.delete();
    aer_req  = 1'b0;
    aer_bit1 = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_addr", int'(ev_addr), 0);
    ev_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    send_frame(8'h12);

    repeat (10) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    check("ferr_count", ferr_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aer_rx_decoder.md
Name: aer_rx_decoder

Overview:
- Receiver end of the AER link. Accepts 2-bit address symbols (bit1, bit0) qualified by a request line, one four-phase handshake per symbol.
- Returns ack to the sender.
- Reassembles ADDR_W/2 symbols, MSB pair first, into one event address.
- Presents the address to the on-chip consumer over a valid/ready interface.
- Sits between the off-chip/asynchronous AER sender and the clocked event-processing logic.

Parameters:
- ADDR_W, 8, event address width; must be even and >= 2; symbols per frame NSYM = ADDR_W/2.
- SETTLE, 2, clk cycles data must be held after synchronised req rises before sampling; must be >= 1.
- TIMEOUT, 64, idle clk cycles allowed between symbols of one frame before the partial frame is discarded.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- aer_req  in  1  sender request (Dt); asynchronous to clk.
- aer_bit0  in  1  symbol LSB; asynchronous, stable while aer_req high.
- aer_bit1  in  1  symbol MSB; asynchronous, stable while aer_req high.
- aer_ack  out  1  handshake acknowledge to sender; registered.
- ev_addr  out  ADDR_W  reassembled event address.
- ev_valid  out  1  ev_addr holds an unconsumed event.
- ev_ready  in  1  consumer accepts ev_addr when ev_valid && ev_ready at clk edge.
- frame_err  out  1  one-cycle pulse: partial frame discarded on timeout.

Behaviour:
- Reset (async assert, sync release) clears all outputs and state.
  - aer_ack=0, ev_valid=0, ev_addr=0, frame_err=0.
  - State IDLE, symbol counter=0, shift register=0, settle and timeout counters=0.
- Synchronisers:
  - aer_req, aer_bit0 and aer_bit1 each pass through a 2-flop synchroniser; req_s, b0_s, b1_s are the synchronised signals.
  - Nothing else samples the raw inputs.
- States:
  - IDLE: aer_ack=0.
    - On req_s=1, go to SETTLE and clear the settle counter.
  - SETTLE: count cycles while req_s=1.
    - If req_s drops before the count completes, return to IDLE (glitch): no sample, no ack.
    - When the counter reaches SETTLE, go to SAMPLE.
  - SAMPLE:
    - If this is the last symbol (counter = NSYM-1) and ev_valid=1 with ev_ready=0, stay in SAMPLE with ack low (back-pressure to sender).
    - Otherwise:
      - Shift {b1_s, b0_s} into the low end of the shift register; the first symbol ends up in ev_addr[ADDR_W-1:ADDR_W-2].
      - Increment the symbol counter.
      - Set aer_ack=1 and go to ACK.
    - On the last symbol: load ev_addr with the completed register, set ev_valid=1 and reset the symbol counter to 0, all in the same cycle.
  - ACK: hold aer_ack=1 until req_s=0, then aer_ack=0 (registered) and go to IDLE.
- Latency, with req and data rising together at cycle 0:
  - req_s high at cycle 2.
  - aer_ack rises at cycle 3+SETTLE.
  - aer_ack falls 3 cycles after aer_req falls.
- Output interface:
  - ev_valid clears on ev_valid && ev_ready, unless a new frame completes in the same cycle; in that case ev_valid stays 1 and ev_addr takes the new value.
  - The SAMPLE stall rule guarantees an unaccepted event is never overwritten.
  - ev_addr is held stable while ev_valid=1 and not accepted.
- Timeout:
  - While in IDLE with symbol counter != 0, a timeout counter increments every cycle; it resets on leaving IDLE.
  - On reaching TIMEOUT: clear the symbol counter and shift register, and pulse frame_err=1 for exactly one cycle.
  - ev_valid and ev_addr are unaffected by a timeout.
- The timeout counter does not run when the symbol counter is 0 (between frames).
- A reset asserted mid-handshake drops aer_ack immediately (async). The partial frame and any pending event are lost.

Test Plan:
- Single frame, ADDR_W=8, SETTLE=2, ev_ready=1:
  - Stimulus: send symbols 2'b10, 2'b01, 2'b11, 2'b00, each with full four-phase handshake.
  - Required: ev_valid pulses one cycle with ev_addr=8'h9C; four aer_ack pulses; aer_ack rises at cycle 5 after req rise.
- Back-pressure:
  - Stimulus: hold ev_ready=0, send frame 8'hA5 then frame 8'h3C.
  - Required:
    - ev_addr stays 8'hA5.
    - aer_ack stays low on the 4th symbol of the second frame until ev_ready=1.
    - Then ev_addr=8'h3C, ev_valid=1, and ack completes.
- Glitch rejection: pulse aer_req high for 2 cycles only -> no aer_ack, symbol counter unchanged, ev_valid=0.
- Timeout:
  - Stimulus: send 2 symbols, then idle 64 cycles.
  - Required: frame_err=1 for one cycle.
  - Follow-up: a subsequent full frame 8'hFF decodes correctly to ev_addr=8'hFF.
- Reset mid-handshake:
  - Stimulus: assert reset while aer_ack=1 during symbol 3.
  - Required: aer_ack=0 and ev_valid=0 in the same cycle; after release, a new frame 8'h12 decodes as 8'h12.
- Simultaneous accept and complete: ev_ready=1 on the cycle the next frame's last symbol samples -> ev_valid remains 1, ev_addr updates to the new value, and no event is dropped.
